// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar units: FSM state codes exposed on db_estado
// and the BCD digit width used by the distance counter.
package sonar_pkg;

  localparam int unsigned BCD_DIGITO_W = 4;

  typedef enum logic [3:0] {
    inicial       = 4'b0000,
    preparacao    = 4'b0001,
    envia_trigger = 4'b0010,
    espera_eco    = 4'b0011,
    mede_eco      = 4'b0100,
    armazena      = 4'b0101,
    falha         = 4'b0111
  } estado_t;

endpackage

// File: rtl/contador_bcd_3dig.sv
// Three-digit BCD up-counter with synchronous clear, saturating at 999.
module contador_bcd_3dig
  import sonar_pkg::*;
(
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_limpa,
  input  logic                        i_conta,
  output logic [3*BCD_DIGITO_W-1:0]   o_valor
);

  localparam logic [BCD_DIGITO_W-1:0] NOVE = BCD_DIGITO_W'(9);
  localparam logic [BCD_DIGITO_W-1:0] UM   = BCD_DIGITO_W'(1);

  logic [BCD_DIGITO_W-1:0] r_uni;
  logic [BCD_DIGITO_W-1:0] r_dez;
  logic [BCD_DIGITO_W-1:0] r_cen;
  logic                    w_saturado;

  assign w_saturado = (r_cen == NOVE) && (r_dez == NOVE) && (r_uni == NOVE);

  always_ff @(posedge i_clock) begin
    if (!i_reset || i_limpa) begin
      r_uni <= '0;
      r_dez <= '0;
      r_cen <= '0;
    end else if (i_conta && !w_saturado) begin
      if (r_uni == NOVE) begin
        r_uni <= '0;
        if (r_dez == NOVE) begin
          r_dez <= '0;
          r_cen <= r_cen + UM;
        end else begin
          r_dez <= r_dez + UM;
        end
      end else begin
        r_uni <= r_uni + UM;
      end
    end
  end

  assign o_valor = {r_cen, r_dez, r_uni};

endmodule

// File: rtl/medidor_eco.sv
// HC-SR04 measurement responder: fires the trigger, times the echo and reports
// the rounded distance in centimetres as three BCD digits.
module medidor_eco
  import sonar_pkg::*;
#(
  parameter int unsigned TRIGGER_CICLOS = 500,
  parameter int unsigned CICLOS_POR_CM  = 2941,
  parameter int unsigned ESPERA_MAX     = 1_000_000,
  parameter int unsigned ECO_MAX        = 1_500_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam int unsigned MAX_A     = (TRIGGER_CICLOS > ESPERA_MAX) ? TRIGGER_CICLOS : ESPERA_MAX;
  localparam int unsigned CONT_TOPO = (MAX_A > ECO_MAX) ? MAX_A : ECO_MAX;
  localparam int unsigned CW        = $clog2(CONT_TOPO + 1);
  localparam int unsigned PW        = $clog2(CICLOS_POR_CM + 1);

  estado_t           r_estado;
  estado_t           w_prox;
  logic              r_echo_m;
  logic              r_echo_s;
  logic [CW-1:0]     r_cont;
  logic [PW-1:0]     r_presc;
  logic [11:0]       r_medida;
  logic              r_erro;
  logic [11:0]       w_bcd;
  logic              w_cont_limpa;
  logic              w_cont_inc;
  logic              w_cont_um;
  logic              w_presc_carrega;
  logic              w_presc_passo;
  logic              w_presc_fim;
  logic              w_bcd_limpa;
  logic              w_bcd_conta;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_echo_m <= 1'b0;
      r_echo_s <= 1'b0;
    end else begin
      r_echo_m <= echo;
      r_echo_s <= r_echo_m;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado <= inicial;
    end else begin
      r_estado <= w_prox;
    end
  end

  // The cycle in espera_eco that first sees echo_s high already counts as one
  // echo cycle, so the pulse width is measured exactly.
  always_comb begin
    w_prox          = r_estado;
    w_cont_limpa    = 1'b0;
    w_cont_inc      = 1'b0;
    w_cont_um       = 1'b0;
    w_presc_carrega = 1'b0;
    w_presc_passo   = 1'b0;
    w_bcd_limpa     = 1'b0;
    case (r_estado)
      inicial: begin
        if (medir) w_prox = preparacao;
      end
      preparacao: begin
        w_cont_limpa    = 1'b1;
        w_presc_carrega = 1'b1;
        w_bcd_limpa     = 1'b1;
        w_prox          = envia_trigger;
      end
      envia_trigger: begin
        if (r_cont == CW'(TRIGGER_CICLOS - 1)) begin
          w_cont_limpa = 1'b1;
          w_prox       = espera_eco;
        end else begin
          w_cont_inc = 1'b1;
        end
      end
      espera_eco: begin
        if (r_echo_s) begin
          w_cont_um     = 1'b1;
          w_presc_passo = 1'b1;
          w_prox        = mede_eco;
        end else if (r_cont == CW'(ESPERA_MAX - 1)) begin
          w_prox = falha;
        end else begin
          w_cont_inc = 1'b1;
        end
      end
      mede_eco: begin
        if (!r_echo_s) begin
          w_prox = armazena;
        end else if (r_cont == CW'(ECO_MAX - 1)) begin
          w_prox = falha;
        end else begin
          w_cont_inc    = 1'b1;
          w_presc_passo = 1'b1;
        end
      end
      armazena: w_prox = inicial;
      falha:    w_prox = inicial;
      default:  w_prox = inicial;
    endcase
  end

  assign w_presc_fim = (r_presc == PW'(CICLOS_POR_CM - 1));
  assign w_bcd_conta = w_presc_passo && w_presc_fim;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cont <= '0;
    end else if (w_cont_limpa) begin
      r_cont <= '0;
    end else if (w_cont_um) begin
      r_cont <= CW'(1);
    end else if (w_cont_inc) begin
      r_cont <= r_cont + CW'(1);
    end
  end

  // Preloading half a centimetre makes the BCD count round to nearest.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (w_presc_carrega) begin
      r_presc <= PW'(CICLOS_POR_CM / 2);
    end else if (w_presc_passo) begin
      if (w_presc_fim) r_presc <= '0;
      else             r_presc <= r_presc + PW'(1);
    end
  end

  contador_bcd_3dig u_bcd (
    .i_clock (clock),
    .i_reset (reset),
    .i_limpa (w_bcd_limpa),
    .i_conta (w_bcd_conta),
    .o_valor (w_bcd)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_medida <= '0;
      r_erro   <= 1'b0;
    end else if ((r_estado == mede_eco) && (w_prox == armazena)) begin
      r_medida <= w_bcd;
      r_erro   <= 1'b0;
    end else if ((w_prox == falha) && (r_estado != falha)) begin
      r_erro <= 1'b1;
    end
  end

  assign trigger   = (r_estado == envia_trigger);
  assign pronto    = (r_estado == armazena) || (r_estado == falha);
  assign medida    = r_medida;
  assign erro      = r_erro;
  assign db_estado = r_estado;

endmodule

// File: tb/tb_medidor_eco.sv
// Bench for medidor_eco: two instances (default-like and CICLOS_POR_CM=1),
// a timestamp/arithmetic reference model and directed measurements.
`timescale 1ns/1ps
module tb_medidor_eco;

  localparam int T   = 10;
  localparam int ESP = 200;
  localparam int C0  = 20;
  localparam int E0  = 500;
  localparam int C1  = 1;
  localparam int E1  = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v   = 2'b00;
  logic [1:0] medir_v = 2'b00;
  logic [1:0] echo_v  = 2'b00;

  logic        trig0, pronto0, erro0, trig1, pronto1, erro1;
  logic [11:0] med0, med1;
  logic [3:0]  db0, db1;

  medidor_eco #(.TRIGGER_CICLOS(T), .CICLOS_POR_CM(C0), .ESPERA_MAX(ESP), .ECO_MAX(E0)) u_dut0 (
    .clock(clk), .reset(rst_v[0]), .medir(medir_v[0]), .echo(echo_v[0]),
    .trigger(trig0), .medida(med0), .pronto(pronto0), .erro(erro0), .db_estado(db0)
  );

  medidor_eco #(.TRIGGER_CICLOS(T), .CICLOS_POR_CM(C1), .ESPERA_MAX(ESP), .ECO_MAX(E1)) u_dut1 (
    .clock(clk), .reset(rst_v[1]), .medir(medir_v[1]), .echo(echo_v[1]),
    .trigger(trig1), .medida(med1), .pronto(pronto1), .erro(erro1), .db_estado(db1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: phases timed by edge timestamps, distance by arithmetic.
  int          cyc = 0;
  int          ph[2];
  int          t0[2];
  int          h[2];
  logic        s1[2];
  logic        s2[2];
  logic [11:0] mmed[2];
  logic        merr[2];

  function automatic logic [11:0] dist_bcd(input int hh, input int c);
    int d;
    d = (hh + c / 2) / c;
    if (d > 999) d = 999;
    return {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
  endfunction

  task automatic entra(input int i, input int p);
    ph[i] = p;
    t0[i] = cyc;
  endtask

  task automatic model_step(input int i);
    int   c;
    int   emax;
    logic es;
    c    = (i == 0) ? C0 : C1;
    emax = (i == 0) ? E0 : E1;
    es   = s2[i];
    if (!rst_v[i]) begin
      ph[i] = 0; h[i] = 0; mmed[i] = '0; merr[i] = 1'b0; s1[i] = 1'b0; s2[i] = 1'b0;
    end else begin
      case (ph[i])
        0: if (medir_v[i]) entra(i, 1);
        1: entra(i, 2);
        2: if (cyc - t0[i] == T) entra(i, 3);
        3: begin
          if (es) begin
            h[i] = 1;
            entra(i, 4);
          end else if (cyc - t0[i] == ESP) begin
            merr[i] = 1'b1;
            entra(i, 7);
          end
        end
        4: begin
          if (!es) begin
            mmed[i] = dist_bcd(h[i], c);
            merr[i] = 1'b0;
            entra(i, 5);
          end else begin
            h[i]++;
            if (h[i] >= emax) begin
              merr[i] = 1'b1;
              entra(i, 7);
            end
          end
        end
        default: entra(i, 0);
      endcase
      s2[i] = s1[i];
      s1[i] = echo_v[i];
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; t0[i] = 0; h[i] = 0; s1[i] = 1'b0; s2[i] = 1'b0; mmed[i] = '0; merr[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc++;
    model_step(0);
    model_step(1);
  end

  int          np[2]   = '{0, 0};
  logic [11:0] lmed[2] = '{12'h0, 12'h0};
  logic        lerr[2] = '{1'b0, 1'b0};

  task automatic cmp_inst(input int i, input logic tg, input logic pr, input logic er,
                          input logic [11:0] md, input logic [3:0] db);
    chk($sformatf("trigger[%0d]", i), tg, ph[i] == 2);
    chk($sformatf("pronto[%0d]", i), pr, (ph[i] == 5) || (ph[i] == 7));
    chk($sformatf("erro[%0d]", i), er, merr[i]);
    chk($sformatf("medida[%0d]", i), md, mmed[i]);
    chk($sformatf("db_estado[%0d]", i), db, ph[i]);
    if (pr) begin
      np[i]++;
      lmed[i] = md;
      lerr[i] = er;
    end
  endtask

  always @(posedge clk) begin
    #1;
    cmp_inst(0, trig0, pronto0, erro0, med0, db0);
    cmp_inst(1, trig1, pronto1, erro1, med1, db1);
  end

  function automatic logic trig_of(input int i);
    return (i == 0) ? trig0 : trig1;
  endfunction

  function automatic logic [3:0] db_of(input int i);
    return (i == 0) ? db0 : db1;
  endfunction

  task automatic medicao(input int i, input string nm, input int atraso, input int larg,
                         input logic [11:0] exp_med, input logic exp_err);
    int k;
    int n0;
    int ntrig;
    n0 = np[i];
    medir_v[i] = 1'b1;
    @(negedge clk);
    medir_v[i] = 1'b0;
    k = 0;
    while (!trig_of(i) && k < 10) begin @(negedge clk); k++; end
    ntrig = 0;
    while (trig_of(i) && ntrig < 50) begin @(negedge clk); ntrig++; end
    chk({nm, " trigger_width"}, ntrig, T);
    chk({nm, " espera_eco"}, db_of(i), 4'h3);
    repeat (atraso) @(negedge clk);
    if (larg > 0) begin
      echo_v[i] = 1'b1;
      repeat (larg) @(negedge clk);
      echo_v[i] = 1'b0;
    end
    k = 0;
    while (np[i] == n0 && k < 3000) begin @(negedge clk); k++; end
    chk({nm, " pronto_count"}, np[i] - n0, 1);
    chk({nm, " medida"}, lmed[i], exp_med);
    chk({nm, " erro"}, lerr[i], exp_err);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int n0;
    rst_v   = 2'b00;
    medir_v = 2'b11;
    echo_v  = 2'b11;
    repeat (4) @(negedge clk);
    chk("reset trigger", trig0, 0);
    chk("reset pronto", pronto0, 0);
    chk("reset erro", erro0, 0);
    chk("reset medida", med0, 12'h000);
    chk("reset db_estado", db0, 4'h0);
    medir_v = 2'b00;
    echo_v  = 2'b00;
    rst_v   = 2'b11;
    repeat (4) @(negedge clk);

    medicao(0, "eco250",  30, 250, 12'h013, 1'b0);
    medicao(0, "sem_eco",  0,   0, 12'h013, 1'b1);
    medicao(0, "eco40",    5,  40, 12'h002, 1'b0);
    medicao(0, "eco9",     5,   9, 12'h000, 1'b0);
    medicao(0, "eco10",    5,  10, 12'h001, 1'b0);
    medicao(0, "eco600",   0, 600, 12'h001, 1'b1);
    medicao(0, "eco499",   3, 499, 12'h025, 1'b0);

    medicao(1, "sat1200",  5, 1200, 12'h999, 1'b0);

    n0 = np[1];
    medir_v[1] = 1'b1;
    @(negedge clk);
    medir_v[1] = 1'b0;
    repeat (12) @(negedge clk);
    echo_v[1] = 1'b1;
    repeat (60) @(negedge clk);
    chk("abort in mede_eco", db1, 4'h4);
    rst_v[1] = 1'b0;
    @(negedge clk);
    chk("abort db_estado", db1, 4'h0);
    chk("abort trigger", trig1, 0);
    @(negedge clk);
    rst_v[1]  = 1'b1;
    echo_v[1] = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort no pronto", np[1] - n0, 0);
    chk("abort medida cleared", med1, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
